// File: rtl/rca_seq_ctrl.sv
// Bit-serial (3-bit slice) adder sequencer around one shared rca slice.
// Define RCA_SEQ_SUB_EN to add the op_sub port for two's-complement subtract.
module rca (
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       cin,
  output logic [2:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {3'b000, cin};
endmodule

module rca_seq_ctrl #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             busy
);
  localparam int NSLICE = WIDTH / 3;
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((WIDTH % 3) != 0 || WIDTH < 3) begin : g_bad_width
    $error("rca_seq_ctrl: WIDTH must be a multiple of 3 and >= 3");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [IW-1:0]    idx_q;
  logic             c_q;
  logic             cout_q;
  logic             rdy_q;
  logic             vld_q;
  logic             busy_q;

  logic [WIDTH-1:0] b_d;
  logic             c_d;
  logic [2:0]       sa;
  logic [2:0]       sb;
  logic [2:0]       ss;
  logic             sco;

  always_comb begin
    b_d = op_b;
    c_d = op_cin;
`ifdef RCA_SEQ_SUB_EN
    if (op_sub) begin
      b_d = ~op_b;
      c_d = 1'b1;
    end
`endif
  end

  always_comb begin
    sa = 3'b000;
    sb = 3'b000;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IW'(i)) begin
        sa = a_q[3*i +: 3];
        sb = b_q[3*i +: 3];
      end
    end
  end

  rca u_rca (
    .a   (sa),
    .b   (sb),
    .cin (c_q),
    .sum (ss),
    .cout(sco)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= op_a;
            b_q     <= b_d;
            c_q     <= c_d;
            idx_q   <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IW'(i)) sum_q[3*i +: 3] <= ss;
          end
          c_q <= sco;
          if (idx_q == IW'(NSLICE - 1)) begin
            cout_q  <= sco;
            idx_q   <= '0;
            vld_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b1;
          vld_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign busy      = busy_q;
  assign res_sum   = sum_q;
  assign res_cout  = cout_q;
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Scoreboard bench for rca_seq_ctrl (WIDTH=12).
// Define RCA_SEQ_SUB_EN to also exercise the subtract path.
module tb_rca_seq_ctrl;
  localparam int WIDTH = 12;
  localparam int NSLICE = WIDTH / 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             op_cin = 1'b0;
  logic             op_sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             busy;

  int tests = 0;
  int fails = 0;
  logic [WIDTH:0] exp_q[$];

  rca_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_cin   (op_cin),
`ifdef RCA_SEQ_SUB_EN
    .op_sub   (op_sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res_sum  (res_sum),
    .res_cout (res_cout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one operation until accepted; push the reference result.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic sub);
    logic [WIDTH:0] e;
    bit was;
    bit ok;
    if (sub)
      e = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    else
      e = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    op_cin = cin;
    op_sub = sub;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      was = in_ready;
      tick();
      ok = was;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL accept: in_ready stayed 0, required 1");
    end else begin
      exp_q.push_back(e);
    end
    in_valid = 1'b0;
    op_a = WIDTH'($urandom);
    op_b = WIDTH'($urandom);
    op_cin = 1'($urandom);
    op_sub = 1'($urandom);
  endtask

  // Wait for the result, check latency/value, stall, then consume.
  task automatic recv(input int stall);
    int n;
    logic [WIDTH:0] e;
    logic [WIDTH-1:0] held;
    n = 0;
    while (!out_valid && n < NSLICE + 10) begin
      tick();
      n++;
      tests++;
      if (busy !== ~in_ready) begin
        fails++;
        $display("FAIL busy: busy=%b in_ready=%b, required busy=~in_ready", busy, in_ready);
      end
    end
    tests++;
    if (n != NSLICE || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL latency: %0d cycles out_valid=%b, required %0d cycles", n, out_valid, NSLICE);
    end
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    if (out_valid !== 1'b1) return;
    tests++;
    if (res_sum !== e[WIDTH-1:0]) begin
      fails++;
      $display("FAIL sum: got %h, required %h", res_sum, e[WIDTH-1:0]);
    end
    tests++;
    if (res_cout !== e[WIDTH]) begin
      fails++;
      $display("FAIL cout: got %b, required %b", res_cout, e[WIDTH]);
    end
    held = res_sum;
    for (int i = 0; i < stall; i++) begin
      tick();
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || res_sum !== held) begin
        fails++;
        $display("FAIL stall: vld=%b rdy=%b sum=%h, required 1 0 %h",
                 out_valid, in_ready, res_sum, held);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL consume: vld=%b rdy=%b busy=%b, required 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        res_sum !== '0 || res_cout !== 1'b0) begin
      fails++;
      $display("FAIL reset: rdy=%b vld=%b busy=%b sum=%h cout=%b, required 1 0 0 000 0",
               in_ready, out_valid, busy, res_sum, res_cout);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_run;
    bit seen;
    send(12'h123, 12'h456, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        res_sum !== '0 || res_cout !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_run: rdy=%b vld=%b busy=%b sum=%h cout=%b, required 1 0 0 000 0",
               in_ready, out_valid, busy, res_sum, res_cout);
    end
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL reset_no_output: out_valid seen=1, required 0");
    end
  endtask

  task automatic test_basic;
    send(12'h123, 12'h456, 1'b0, 1'b0);
    recv(0);
    send(12'h0A5, 12'h35A, 1'b1, 1'b0);
    recv(1);
  endtask

  task automatic test_carry_chain;
    send(12'hFFF, 12'h000, 1'b1, 1'b0);
    recv(0);
    send(12'hFFF, 12'hFFF, 1'b1, 1'b0);
    recv(0);
  endtask

  task automatic test_backpressure;
    send(12'h321, 12'h654, 1'b0, 1'b0);
    in_valid = 1'b1;
    op_a = 12'h777;
    op_b = 12'h111;
    op_cin = 1'b1;
    op_sub = 1'b0;
    recv(10);
    send(12'h777, 12'h111, 1'b1, 1'b0);
    recv(0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) begin
      send(WIDTH'(12'h200 + i), 12'h0FF, 1'b1, 1'b0);
      recv(0);
    end
  endtask

  task automatic test_random;
    logic s;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      s = 1'b0;
`ifdef RCA_SEQ_SUB_EN
      s = 1'($urandom);
`endif
      send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), s);
      recv($urandom_range(0, 3));
    end
  endtask

`ifdef RCA_SEQ_SUB_EN
  task automatic test_sub;
    send(12'h005, 12'h007, 1'b0, 1'b1);
    recv(0);
    send(12'h007, 12'h005, 1'b0, 1'b1);
    recv(0);
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_run();
    test_basic();
    test_carry_chain();
    test_backpressure();
    test_back_to_back();
`ifdef RCA_SEQ_SUB_EN
    test_sub();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
